spi_mstr_param: RTL

Parametrised SPI master, successor to the fixed 16-bit, mode-0, single-slave master. It supports configurable word width, a runtime SCLK divider, all four CPOL/CPHA modes and NUM_SS one-hot slave selects. It sits between host/command logic (wrt/cmd handshake) and external SPI pins. It produces a one-cycle done pulse with the received word.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_edge_gen.sv | 38 +++
 rtl/spi_mstr_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and sizing helpers for the parametrised SPI master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_SS = 4;
    localparam int DEF_DIV_W  = 8;

    // Number of SCLK edges in one word: one leading and one trailing per bit.
    function automatic int edge_count(input int data_w);
        return 2 * data_w;
    endfunction

    // $clog2 that never returns zero, so single-entry selects still get a 1-bit port.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// rtl/spi_edge_gen.sv - SCLK half-period divider with terminal-count strobe and edge phase
module spi_edge_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             edge_en,
    input  logic [DIV_W-1:0] n_m1,
    output logic             tick,
    output logic             lead
);

    logic [DIV_W-1:0] cnt;

    // Strobe on the last count of each half-period; the counter never exceeds n_m1.
    assign tick = en && (cnt == n_m1);

    // Divider counts 0..N-1 and wraps while the transfer is running.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // Tracks whether the next SCLK edge is leading (odd) or trailing (even).
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lead <= 1'b1;
        end else if (tick && edge_en) begin
            lead <= ~lead;
        end
    end

endmodule

// File: rtl/spi_mstr_param.sv
// rtl/spi_mstr_param.sv - parametrised SPI master: FSM, shift registers and slave-select decode
module spi_mstr_param
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_SS = DEF_NUM_SS,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wrt,
    input  logic [DATA_W-1:0]             cmd,
    input  logic [clog2_min1(NUM_SS)-1:0] ss_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic [DIV_W-1:0]              half_div,
    input  logic                          MISO,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rd_data,
    output logic [NUM_SS-1:0]             SS_n,
    output logic                          SCLK,
    output logic                          MOSI
);

    localparam int EDGES   = edge_count(DATA_W);
    localparam int EDGE_CW = clog2_min1(EDGES + 1);
    localparam int SS_W    = clog2_min1(NUM_SS);

    spi_state_t           state;
    spi_state_t           state_nxt;
    spi_mode_t            mode_q;
    logic [SS_W-1:0]      ss_q;
    logic [DIV_W-1:0]     n_m1;
    logic [DATA_W-1:0]    tx_sr;
    logic [DATA_W-1:0]    rx_sr;
    logic [EDGE_CW-1:0]   edge_cnt;
    logic                 tick;
    logic                 lead;
    logic                 accept;
    logic                 edge_phase;
    logic                 last_edge;
    logic                 ss_active;

    assign accept     = (state == IDLE) && wrt;
    assign edge_phase = (state == SETUP) || (state == XFER);
    assign last_edge  = (edge_cnt == EDGE_CW'(EDGES - 1));

    spi_edge_gen #(.DIV_W(DIV_W)) u_edge_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (state != IDLE),
        .edge_en (edge_phase),
        .n_m1    (n_m1),
        .tick    (tick),
        .lead    (lead)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: every non-idle phase advances on a divider strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wrt) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = GAP;
            GAP:     if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded outputs: busy for the whole transaction, one select low until HOLD ends.
    always_comb begin
        busy      = (state != IDLE);
        ss_active = (state == SETUP) || (state == XFER) || (state == HOLD);
        SS_n      = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_active && (int'(ss_q) == i)) SS_n[i] = 1'b0;
        end
    end

    // Datapath: latch request, toggle SCLK, shift MOSI out and MISO in, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            ss_q     <= '0;
            n_m1     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mode_q   <= '{cpol: cpol, cpha: cpha};
                ss_q     <= ss_sel;
                n_m1     <= (half_div == '0) ? '0 : half_div - 1'b1;
                edge_cnt <= '0;
                rx_sr    <= '0;
                SCLK     <= cpol;
                // With cpha=0 the first bit must be on the wire before the first edge.
                if (!cpha) begin
                    MOSI  <= cmd[DATA_W-1];
                    tx_sr <= cmd << 1;
                end else begin
                    tx_sr <= cmd;
                end
            end else if (tick && edge_phase) begin
                SCLK     <= ~SCLK;
                edge_cnt <= edge_cnt + 1'b1;
                if ((lead == mode_q.cpha) && (mode_q.cpha || !last_edge)) begin
                    MOSI  <= tx_sr[DATA_W-1];
                    tx_sr <= tx_sr << 1;
                end
                if (lead != mode_q.cpha) begin
                    rx_sr <= {rx_sr[DATA_W-2:0], MISO};
                end
            end else if (state == IDLE) begin
                SCLK <= mode_q.cpol;
            end
            if ((state == GAP) && tick) begin
                done    <= 1'b1;
                rd_data <= rx_sr;
            end
        end
    end

endmodule
